seq_hit_monitor: RTL and testbench

- Downstream consumer of the 110110 Moore sequence detector's output z.
- Counts detection cycles over a programmable sampling window and publishes the per-window count.
- Raises a sticky alarm when a window's count reaches a programmable threshold.
- Sits between the detector and the status/interrupt logic.

---
 rtl/seq_hit_monitor.sv | 91 +++++++++
 tb/tb_seq_hit_monitor.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_hit_monitor.sv
// Windowed hit counter for the 110110 detector output: publishes a per-window
// hit count and raises a sticky alarm when a window reaches the threshold.
//
// state | meaning
// IDLE  | monitor disabled, timer and running count held at zero
// RUN   | counting hits against the window timer
module seq_hit_monitor #(
  parameter int CNT_W = 8,
  parameter int WIN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             hit,
  input  logic [WIN_W-1:0] win_len,
  input  logic [CNT_W-1:0] thresh,
  input  logic             clr,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] win_count,
  output logic             win_done,
  output logic             alarm
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state;
  logic [WIN_W-1:0] timer;
  logic [CNT_W-1:0] hit_sum;
  logic             terminal;
  logic             alarm_set;

  // win_len of 0 makes the terminal compare land on all-ones, i.e. a full 2^WIN_W window
  always_comb begin
    hit_sum   = (hit && (hit_count != {CNT_W{1'b1}})) ? hit_count + CNT_W'(1) : hit_count;
    terminal  = (timer == (win_len - WIN_W'(1)));
    alarm_set = (state == RUN) && en && terminal &&
                (thresh != '0) && (hit_sum >= thresh);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      timer     <= '0;
      hit_count <= '0;
      win_count <= '0;
      win_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          timer     <= '0;
          hit_count <= '0;
          win_done  <= 1'b0;
          if (en) state <= RUN;
        end
        RUN: begin
          if (!en) begin
            // partial window is discarded; win_count keeps the last full result
            state     <= IDLE;
            timer     <= '0;
            hit_count <= '0;
            win_done  <= 1'b0;
          end else if (terminal) begin
            win_count <= hit_sum;
            hit_count <= '0;
            timer     <= '0;
            win_done  <= 1'b1;
          end else begin
            timer     <= timer + WIN_W'(1);
            hit_count <= hit_sum;
            win_done  <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          timer     <= '0;
          hit_count <= '0;
          win_done  <= 1'b0;
        end
      endcase
    end
  end

  // a terminal cycle that sets the alarm takes priority over a same-cycle clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           alarm <= 1'b0;
    else if (alarm_set) alarm <= 1'b1;
    else if (clr)       alarm <= 1'b0;
  end

endmodule

// File: tb/tb_seq_hit_monitor.sv
// Directed self-checking bench for seq_hit_monitor (CNT_W=8, WIN_W=8).
module tb_seq_hit_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       hit = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] win_len = 8'd0;
  logic [7:0] thresh = 8'd0;
  logic [7:0] hit_count;
  logic [7:0] win_count;
  logic       win_done;
  logic       alarm;

  int pass_cnt = 0;
  int total_cnt = 0;

  seq_hit_monitor #(.CNT_W(8), .WIN_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .hit(hit), .win_len(win_len),
    .thresh(thresh), .clr(clr), .hit_count(hit_count),
    .win_count(win_count), .win_done(win_done), .alarm(alarm)
  );

  always #5 clk = ~clk;

  // one rising edge, then settle so outputs are read away from the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2;
    total_cnt++;
    if (hit_count !== 8'd0) $display("FAIL reset_hit_count: got %0d expected 0", hit_count); else pass_cnt++;
    total_cnt++;
    if (win_count !== 8'd0) $display("FAIL reset_win_count: got %0d expected 0", win_count); else pass_cnt++;
    total_cnt++;
    if (win_done !== 1'b0) $display("FAIL reset_win_done: got %b expected 0", win_done); else pass_cnt++;
    total_cnt++;
    if (alarm !== 1'b0) $display("FAIL reset_alarm: got %b expected 0", alarm); else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic_window();
    int exp_hc;
    int pulses;
    exp_hc = 0;
    pulses = 0;
    win_len = 8'd8; thresh = 8'd0; en = 1'b1; hit = 1'b1;
    tick();
    total_cnt++;
    if (hit_count !== 8'd0) $display("FAIL basic_entry_ignores_hit: got %0d expected 0", hit_count); else pass_cnt++;
    for (int c = 0; c < 8; c++) begin
      hit = (c == 1 || c == 4 || c == 6);
      if (hit) exp_hc++;
      tick();
      if (win_done) pulses++;
      if (c < 7) begin
        total_cnt++;
        if (hit_count !== 8'(exp_hc)) $display("FAIL basic_hit_count_c%0d: got %0d expected %0d", c, hit_count, exp_hc); else pass_cnt++;
      end
    end
    total_cnt++;
    if (win_count !== 8'd3) $display("FAIL basic_win_count: got %0d expected 3", win_count); else pass_cnt++;
    total_cnt++;
    if (win_done !== 1'b1) $display("FAIL basic_win_done: got %b expected 1", win_done); else pass_cnt++;
    total_cnt++;
    if (hit_count !== 8'd0) $display("FAIL basic_hit_count_cleared: got %0d expected 0", hit_count); else pass_cnt++;
    total_cnt++;
    if (alarm !== 1'b0) $display("FAIL basic_alarm: got %b expected 0", alarm); else pass_cnt++;
    hit = 1'b0;
    tick();
    if (win_done) pulses++;
    total_cnt++;
    if (pulses !== 1) $display("FAIL basic_done_pulses: got %0d expected 1", pulses); else pass_cnt++;
    en = 1'b0;
    tick();
  endtask

  task automatic test_alarm();
    win_len = 8'd4; thresh = 8'd2; en = 1'b1; hit = 1'b0; clr = 1'b0;
    tick();
    for (int c = 0; c < 4; c++) begin
      hit = (c == 1 || c == 3);
      tick();
    end
    total_cnt++;
    if (win_count !== 8'd2) $display("FAIL alarm_win_count: got %0d expected 2", win_count); else pass_cnt++;
    total_cnt++;
    if (alarm !== 1'b1) $display("FAIL alarm_set: got %b expected 1", alarm); else pass_cnt++;
    hit = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    total_cnt++;
    if (win_count !== 8'd0) $display("FAIL alarm_empty_window: got %0d expected 0", win_count); else pass_cnt++;
    total_cnt++;
    if (alarm !== 1'b1) $display("FAIL alarm_sticky: got %b expected 1", alarm); else pass_cnt++;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    total_cnt++;
    if (alarm !== 1'b0) $display("FAIL alarm_clr: got %b expected 0", alarm); else pass_cnt++;
    total_cnt++;
    if (win_count !== 8'd0) $display("FAIL alarm_clr_keeps_win_count: got %0d expected 0", win_count); else pass_cnt++;
    en = 1'b0;
    tick();
  endtask

  task automatic test_clr_set_collision();
    win_len = 8'd4; thresh = 8'd1; en = 1'b1; hit = 1'b0; clr = 1'b0;
    tick();
    for (int c = 0; c < 4; c++) begin
      hit = (c == 3);
      clr = (c == 3);
      tick();
    end
    total_cnt++;
    if (alarm !== 1'b1) $display("FAIL collision_set_wins: got %b expected 1", alarm); else pass_cnt++;
    total_cnt++;
    if (win_count !== 8'd1) $display("FAIL collision_win_count: got %0d expected 1", win_count); else pass_cnt++;
    hit = 1'b0;
    tick();
    clr = 1'b0;
    total_cnt++;
    if (alarm !== 1'b0) $display("FAIL collision_later_clr: got %b expected 0", alarm); else pass_cnt++;
    en = 1'b0;
    tick();
  endtask

  task automatic test_saturation();
    int pulses;
    pulses = 0;
    win_len = 8'd0; thresh = 8'd0; en = 1'b1; hit = 1'b1;
    tick();
    for (int c = 0; c < 256; c++) begin
      tick();
      if (c < 255 && win_done) pulses++;
      if (c == 254) begin
        total_cnt++;
        if (hit_count !== 8'd255) $display("FAIL sat_hit_count: got %0d expected 255", hit_count); else pass_cnt++;
      end
    end
    total_cnt++;
    if (pulses !== 0) $display("FAIL sat_early_done: got %0d expected 0", pulses); else pass_cnt++;
    total_cnt++;
    if (win_done !== 1'b1) $display("FAIL sat_win_done: got %b expected 1", win_done); else pass_cnt++;
    total_cnt++;
    if (win_count !== 8'd255) $display("FAIL sat_win_count: got %0d expected 255", win_count); else pass_cnt++;
    total_cnt++;
    if (hit_count !== 8'd0) $display("FAIL sat_hit_count_cleared: got %0d expected 0", hit_count); else pass_cnt++;
    hit = 1'b0; en = 1'b0;
    tick();
  endtask

  task automatic test_en_drop();
    int pulses;
    pulses = 0;
    win_len = 8'd10; thresh = 8'd0; en = 1'b1; hit = 1'b0;
    tick();
    for (int c = 0; c < 5; c++) begin
      hit = (c == 0 || c == 2);
      tick();
    end
    total_cnt++;
    if (hit_count !== 8'd2) $display("FAIL drop_partial_count: got %0d expected 2", hit_count); else pass_cnt++;
    en = 1'b0; hit = 1'b1;
    tick();
    total_cnt++;
    if (hit_count !== 8'd0) $display("FAIL drop_hit_count: got %0d expected 0", hit_count); else pass_cnt++;
    total_cnt++;
    if (win_done !== 1'b0) $display("FAIL drop_win_done: got %b expected 0", win_done); else pass_cnt++;
    total_cnt++;
    if (win_count !== 8'd255) $display("FAIL drop_win_count_held: got %0d expected 255", win_count); else pass_cnt++;
    en = 1'b1; hit = 1'b0;
    tick();
    for (int c = 0; c < 10; c++) begin
      hit = (c == 9);
      tick();
      if (c < 9 && win_done) pulses++;
    end
    total_cnt++;
    if (pulses !== 0) $display("FAIL restart_early_done: got %0d expected 0", pulses); else pass_cnt++;
    total_cnt++;
    if (win_done !== 1'b1) $display("FAIL restart_win_done: got %b expected 1", win_done); else pass_cnt++;
    total_cnt++;
    if (win_count !== 8'd1) $display("FAIL restart_win_count: got %0d expected 1", win_count); else pass_cnt++;
    hit = 1'b0; en = 1'b0;
    tick();
  endtask

  task automatic test_winlen_change();
    win_len = 8'd10; thresh = 8'd0; en = 1'b1; hit = 1'b0;
    tick();
    hit = 1'b1;
    for (int c = 0; c < 3; c++) tick();
    win_len = 8'd5; hit = 1'b0;
    tick();
    total_cnt++;
    if (win_done !== 1'b0) $display("FAIL shrink_not_yet: got %b expected 0", win_done); else pass_cnt++;
    tick();
    total_cnt++;
    if (win_done !== 1'b1) $display("FAIL shrink_done: got %b expected 1", win_done); else pass_cnt++;
    total_cnt++;
    if (win_count !== 8'd3) $display("FAIL shrink_win_count: got %0d expected 3", win_count); else pass_cnt++;
    en = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    win_len = 8'd4; thresh = 8'd1; en = 1'b1; hit = 1'b0; clr = 1'b0;
    tick();
    for (int c = 0; c < 4; c++) begin
      hit = (c == 0);
      tick();
    end
    total_cnt++;
    if (alarm !== 1'b1) $display("FAIL areset_pre_alarm: got %b expected 1", alarm); else pass_cnt++;
    hit = 1'b1;
    tick();
    tick();
    total_cnt++;
    if (hit_count !== 8'd2) $display("FAIL areset_pre_count: got %0d expected 2", hit_count); else pass_cnt++;
    #3;
    rst = 1'b0;
    #1;
    total_cnt++;
    if (hit_count !== 8'd0) $display("FAIL areset_hit_count: got %0d expected 0", hit_count); else pass_cnt++;
    total_cnt++;
    if (win_count !== 8'd0) $display("FAIL areset_win_count: got %0d expected 0", win_count); else pass_cnt++;
    total_cnt++;
    if (win_done !== 1'b0) $display("FAIL areset_win_done: got %b expected 0", win_done); else pass_cnt++;
    total_cnt++;
    if (alarm !== 1'b0) $display("FAIL areset_alarm: got %b expected 0", alarm); else pass_cnt++;
    #2;
    rst = 1'b1;
    tick();
    total_cnt++;
    if (hit_count !== 8'd0) $display("FAIL areset_reentry: got %0d expected 0", hit_count); else pass_cnt++;
    tick();
    total_cnt++;
    if (hit_count !== 8'd1) $display("FAIL areset_first_hit: got %0d expected 1", hit_count); else pass_cnt++;
    hit = 1'b0; en = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_window();
    test_alarm();
    test_clr_set_collision();
    test_saturation();
    test_en_drop();
    test_winlen_change();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
